// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side signal bundle for the shared camera I2C bus arbiter.
// The master modport is a requester's view; the slave modport is the arbiter's view.
interface i2c_bus_arbiter_if;
    logic       REQ0;
    logic       REQ1;
    logic       GNT0;
    logic       GNT1;
    logic       SCL0;
    logic       SCL1;
    logic       SDA_OE0;
    logic       SDA_OE1;
    logic       SDA_IN;
    logic [1:0] OWNER;
    logic       TIMEOUT_ERR;

    modport master (
        output REQ0, REQ1, SCL0, SCL1, SDA_OE0, SDA_OE1,
        input  GNT0, GNT1, SDA_IN, OWNER, TIMEOUT_ERR
    );

    modport slave (
        input  REQ0, REQ1, SCL0, SCL1, SDA_OE0, SDA_OE1,
        output GNT0, GNT1, SDA_IN, OWNER, TIMEOUT_ERR
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Two-requester round-robin arbiter for the camera I2C pads, with a post-release
// guard gap and a per-grant watchdog that locks out a stuck requester.
//
//   state  | meaning
//   IDLE   | bus free, waiting for an eligible request
//   GRANT0 | requester 0 owns SCL/SDA pads
//   GRANT1 | requester 1 owns SCL/SDA pads
//   GUARD  | bus idle gap before the next owner may be granted
module i2c_bus_arbiter #(
    parameter int GUARD_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic CLK_50,
    input  logic RESET_N,
    input  logic BUS_EN,
    i2c_bus_arbiter_if.slave bus,
    output logic I2C_SCL,
    inout  wire  I2C_SDA
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GUARD} state_t;

    localparam logic [25:0] WD_LAST    = 26'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]  GUARD_LAST = 10'(GUARD_CYCLES - 1);

    state_t      state;
    logic        last;
    logic        lock0;
    logic        lock1;
    logic [25:0] wd_cnt;
    logic [9:0]  guard_cnt;
    logic        elig0;
    logic        elig1;
    logic        sda_pull;

    assign elig0 = bus.REQ0 & ~lock0 & BUS_EN;
    assign elig1 = bus.REQ1 & ~lock1 & BUS_EN;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            last            <= 1'b1;
            lock0           <= 1'b0;
            lock1           <= 1'b0;
            wd_cnt          <= '0;
            guard_cnt       <= '0;
            bus.GNT0        <= 1'b0;
            bus.GNT1        <= 1'b0;
            bus.OWNER       <= 2'b00;
            bus.TIMEOUT_ERR <= 1'b0;
        end else begin
            bus.TIMEOUT_ERR <= 1'b0;
            if (!bus.REQ0) lock0 <= 1'b0;
            if (!bus.REQ1) lock1 <= 1'b0;

            case (state)
                IDLE: begin
                    // last only moves on real contention, so a lone request never steals the next tie
                    if (elig0 && (!elig1 || last)) begin
                        state     <= GRANT0;
                        bus.GNT0  <= 1'b1;
                        bus.OWNER <= 2'b01;
                        wd_cnt    <= '0;
                        if (elig1) last <= 1'b0;
                    end else if (elig1) begin
                        state     <= GRANT1;
                        bus.GNT1  <= 1'b1;
                        bus.OWNER <= 2'b10;
                        wd_cnt    <= '0;
                        if (elig0) last <= 1'b1;
                    end
                end

                GRANT0: begin
                    if (!bus.REQ0 || !BUS_EN || wd_cnt == WD_LAST) begin
                        state     <= GUARD;
                        bus.GNT0  <= 1'b0;
                        bus.OWNER <= 2'b00;
                        guard_cnt <= GUARD_LAST;
                        if (bus.REQ0 && BUS_EN) begin
                            bus.TIMEOUT_ERR <= 1'b1;
                            lock0           <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 26'd1;
                    end
                end

                GRANT1: begin
                    if (!bus.REQ1 || !BUS_EN || wd_cnt == WD_LAST) begin
                        state     <= GUARD;
                        bus.GNT1  <= 1'b0;
                        bus.OWNER <= 2'b00;
                        guard_cnt <= GUARD_LAST;
                        if (bus.REQ1 && BUS_EN) begin
                            bus.TIMEOUT_ERR <= 1'b1;
                            lock1           <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 26'd1;
                    end
                end

                GUARD: begin
                    if (guard_cnt == 10'd0) state <= IDLE;
                    else                    guard_cnt <= guard_cnt - 10'd1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Pads follow the registered state only, so an async reset releases them at once
    always_comb begin
        I2C_SCL  = 1'b1;
        sda_pull = 1'b0;
        case (state)
            GRANT0: begin
                I2C_SCL  = bus.SCL0;
                sda_pull = bus.SDA_OE0;
            end
            GRANT1: begin
                I2C_SCL  = bus.SCL1;
                sda_pull = bus.SDA_OE1;
            end
            default: begin
                I2C_SCL  = 1'b1;
                sda_pull = 1'b0;
            end
        endcase
    end

    assign I2C_SDA    = sda_pull ? 1'b0 : 1'bz;
    assign bus.SDA_IN = I2C_SDA;

endmodule
